// File: rtl/parking_gate_controller_pkg.sv
// Shared constants for the parking gate controller slice: lot geometry,
// FSM state encodings and arbitration grant encodings.
package parking_gate_controller_pkg;

    localparam int unsigned NUM_SLOTS      = 8;
    localparam int unsigned SLOT_W         = 3;
    localparam int unsigned TIMEOUT_CYCLES = 255;

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_ENTRY_OPEN = 2'd1;
    localparam logic [1:0] S_EXIT_OPEN  = 2'd2;

    localparam logic G_ENTRY = 1'b0;
    localparam logic G_EXIT  = 1'b1;

endpackage

// File: rtl/parking_slot_finder.sv
// Combinational priority encoder: index of the lowest free (0) occupancy bit,
// with none_free raised when every slot is taken.
module parking_slot_finder #(
    parameter int unsigned NUM_SLOTS = parking_gate_controller_pkg::NUM_SLOTS,
    parameter int unsigned SLOT_W    = parking_gate_controller_pkg::SLOT_W
) (
    input  logic [NUM_SLOTS-1:0] occupancy,
    output logic [SLOT_W-1:0]    free_slot,
    output logic                 none_free
);

    always_comb begin
        free_slot = '0;
        none_free = 1'b1;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!occupancy[i] && none_free) begin
                free_slot = SLOT_W'(i);
                none_free = 1'b0;
            end
        end
    end

endmodule

// File: rtl/parking_gate_controller.sv
// Entry/exit gate sequencer and slot-occupancy owner for the parking lot.
// Optional gate abort timer enabled by defining GATE_TIMEOUT_EN.
module parking_gate_controller #(
    parameter int unsigned NUM_SLOTS      = parking_gate_controller_pkg::NUM_SLOTS,
    parameter int unsigned SLOT_W         = parking_gate_controller_pkg::SLOT_W,
    parameter int unsigned TIMEOUT_CYCLES = parking_gate_controller_pkg::TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SLOT_W-1:0]    exit_slot,
    input  logic                 car_passed,
    output logic                 entry_gate_open,
    output logic                 exit_gate_open,
    output logic [SLOT_W-1:0]    assigned_slot,
    output logic                 assigned_valid,
    output logic [NUM_SLOTS-1:0] occupancy,
    output logic                 full,
    output logic                 busy,
    output logic                 exit_err
`ifdef GATE_TIMEOUT_EN
    ,
    output logic                 timeout_pulse
`endif
);

    import parking_gate_controller_pkg::*;

    localparam logic [NUM_SLOTS-1:0] SLOT_ONE = NUM_SLOTS'(1);

    logic [1:0]        state;
    logic              last_grant;
    logic [SLOT_W-1:0] exit_latched;
    logic [SLOT_W-1:0] free_slot;
    logic              none_free;
    logic              entry_ok;
    logic              exit_ok;
    logic              grant_entry;
    logic              grant_exit;
`ifdef GATE_TIMEOUT_EN
    logic [7:0]        tmo_cnt;
    logic              tmo_hit;
`endif

    parking_slot_finder #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_slot_finder (
        .occupancy (occupancy),
        .free_slot (free_slot),
        .none_free (none_free)
    );

    assign full            = &occupancy;
    assign busy            = (state != S_IDLE);
    assign entry_gate_open = (state == S_ENTRY_OPEN);
    assign exit_gate_open  = (state == S_EXIT_OPEN);

    // Round robin on contention; a full lot leaves entry ineligible so exit wins.
    always_comb begin
        entry_ok    = entry_req & ~none_free;
        exit_ok     = exit_req & occupancy[exit_slot];
        grant_exit  = exit_ok & (~entry_ok | (last_grant == G_ENTRY));
        grant_entry = entry_ok & ~grant_exit;
    end

`ifdef GATE_TIMEOUT_EN
    assign tmo_hit = (tmo_cnt == 8'(TIMEOUT_CYCLES));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            last_grant     <= G_EXIT;
            occupancy      <= '0;
            assigned_slot  <= '0;
            assigned_valid <= 1'b0;
            exit_err       <= 1'b0;
            exit_latched   <= '0;
`ifdef GATE_TIMEOUT_EN
            tmo_cnt        <= '0;
            timeout_pulse  <= 1'b0;
`endif
        end else begin
            assigned_valid <= 1'b0;
            exit_err       <= 1'b0;
`ifdef GATE_TIMEOUT_EN
            timeout_pulse  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
`ifdef GATE_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    if (exit_req && !occupancy[exit_slot])
                        exit_err <= 1'b1;
                    if (grant_exit) begin
                        state        <= S_EXIT_OPEN;
                        exit_latched <= exit_slot;
                        last_grant   <= G_EXIT;
                    end else if (grant_entry) begin
                        state          <= S_ENTRY_OPEN;
                        assigned_slot  <= free_slot;
                        assigned_valid <= 1'b1;
                        occupancy      <= occupancy | (SLOT_ONE << free_slot);
                        last_grant     <= G_ENTRY;
                    end
                end
                S_ENTRY_OPEN: begin
                    if (car_passed) begin
                        state <= S_IDLE;
`ifdef GATE_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        // Car never came through: give the reserved slot back.
                        state         <= S_IDLE;
                        timeout_pulse <= 1'b1;
                        occupancy     <= occupancy & ~(SLOT_ONE << assigned_slot);
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
`endif
                    end
                end
                S_EXIT_OPEN: begin
                    if (car_passed) begin
                        state     <= S_IDLE;
                        occupancy <= occupancy & ~(SLOT_ONE << exit_latched);
`ifdef GATE_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        state         <= S_IDLE;
                        timeout_pulse <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Self-checking bench for parking_gate_controller: directed scenarios plus
// randomized traffic against a behavioural lot model (GATE_TIMEOUT_EN aware).
module tb_parking_gate_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       entry_req;
    logic       exit_req;
    logic [2:0] exit_slot;
    logic       car_passed;
    logic       entry_gate_open;
    logic       exit_gate_open;
    logic [2:0] assigned_slot;
    logic       assigned_valid;
    logic [7:0] occupancy;
    logic       full;
    logic       busy;
    logic       exit_err;
`ifdef GATE_TIMEOUT_EN
    logic       timeout_pulse;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 = waiting, 1 = entry gate up, 2 = exit gate up.
    int       m_mode;
    bit [7:0] m_occ;
    bit       m_last_exit;
    int       m_slot;
    int       m_held;
    bit       m_valid;
    bit       m_err;
    bit       m_tmo;
    int       m_open_cycles;

    always #5 clk = ~clk;

    parking_gate_controller dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .entry_req       (entry_req),
        .exit_req        (exit_req),
        .exit_slot       (exit_slot),
        .car_passed      (car_passed),
        .entry_gate_open (entry_gate_open),
        .exit_gate_open  (exit_gate_open),
        .assigned_slot   (assigned_slot),
        .assigned_valid  (assigned_valid),
        .occupancy       (occupancy),
        .full            (full),
        .busy            (busy),
        .exit_err        (exit_err)
`ifdef GATE_TIMEOUT_EN
        ,
        .timeout_pulse   (timeout_pulse)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_occ = 8'h00; m_last_exit = 1'b1; m_slot = 0; m_held = 0;
        m_valid = 1'b0; m_err = 1'b0; m_tmo = 1'b0; m_open_cycles = 0;
    endtask

    function automatic int lowest_free(input bit [7:0] occ);
        int s = -1;
        for (int i = 7; i >= 0; i--)
            if (!occ[i]) s = i;
        return s;
    endfunction

    task automatic model_clock();
        bit want_in, want_out;
        m_valid = 1'b0; m_err = 1'b0; m_tmo = 1'b0;
        if (m_mode == 0) begin
            want_in  = entry_req && (m_occ != 8'hFF);
            want_out = exit_req && m_occ[exit_slot];
            if (exit_req && !m_occ[exit_slot]) m_err = 1'b1;
            if (want_in && want_out) want_in = m_last_exit;
            if (want_in) want_out = 1'b0;
            if (want_out) begin
                m_mode = 2; m_held = int'(exit_slot); m_last_exit = 1'b1; m_open_cycles = 0;
            end else if (want_in) begin
                m_slot = lowest_free(m_occ);
                m_occ[m_slot] = 1'b1;
                m_valid = 1'b1; m_mode = 1; m_last_exit = 1'b0; m_open_cycles = 0;
            end
        end else if (car_passed) begin
            if (m_mode == 2) m_occ[m_held] = 1'b0;
            m_mode = 0;
        end else begin
`ifdef GATE_TIMEOUT_EN
            if (m_open_cycles == 255) begin
                if (m_mode == 1) m_occ[m_slot] = 1'b0;
                m_tmo = 1'b1; m_mode = 0;
            end else
                m_open_cycles++;
`endif
        end
    endtask

    task automatic compare_all();
        check("entry_gate", 32'(entry_gate_open), 32'(m_mode == 1));
        check("exit_gate", 32'(exit_gate_open), 32'(m_mode == 2));
        check("busy", 32'(busy), 32'(m_mode != 0));
        check("occupancy", 32'(occupancy), 32'(m_occ));
        check("full", 32'(full), 32'(m_occ == 8'hFF));
        check("assigned_slot", 32'(assigned_slot), 32'(m_slot));
        check("assigned_valid", 32'(assigned_valid), 32'(m_valid));
        check("exit_err", 32'(exit_err), 32'(m_err));
`ifdef GATE_TIMEOUT_EN
        check("timeout_pulse", 32'(timeout_pulse), 32'(m_tmo));
`endif
    endtask

    // Inputs are stable from 1ns after the previous edge; outputs sampled 1ns after this edge.
    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic set_in(input bit en, input bit ex, input int slot, input bit pass);
        entry_req = en; exit_req = ex; exit_slot = 3'(slot); car_passed = pass;
    endtask

    initial begin
        set_in(0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_occupancy", 32'(occupancy), 32'h00);
        check("reset_gates", 32'({entry_gate_open, exit_gate_open}), 32'd0);
        rst_n = 1'b1;

        // First car into an empty lot
        set_in(1, 0, 0, 0); step();
        check("first_slot", 32'(assigned_slot), 32'd0);
        check("first_valid", 32'(assigned_valid), 32'd1);
        check("first_occ", 32'(occupancy), 32'h01);
        check("first_gate", 32'(entry_gate_open), 32'd1);
        set_in(0, 0, 0, 1); step();
        check("first_close", 32'(entry_gate_open), 32'd0);

        // Fill the lot
        for (int k = 1; k < 8; k++) begin
            set_in(1, 0, 0, 0); step();
            check("fill_slot", 32'(assigned_slot), 32'(k));
            set_in(0, 0, 0, 1); step();
        end
        check("fill_occ", 32'(occupancy), 32'hFF);
        check("fill_full", 32'(full), 32'd1);

        // Entry refused while full
        set_in(1, 0, 0, 0); step(); step();
        check("full_no_gate", 32'(entry_gate_open), 32'd0);
        check("full_no_valid", 32'(assigned_valid), 32'd0);

        // Exit slot 3 frees it; next entry takes slot 3
        set_in(0, 1, 3, 0); step();
        check("exit3_gate", 32'(exit_gate_open), 32'd1);
        set_in(0, 0, 0, 1); step();
        check("exit3_occ", 32'(occupancy), 32'hF7);
        check("exit3_full", 32'(full), 32'd0);
        set_in(1, 0, 0, 0); step();
        check("reuse_slot", 32'(assigned_slot), 32'd3);
        set_in(0, 0, 0, 1); step();

        // Last grant was entry: simultaneous requests serve exit first
        set_in(1, 1, 0, 0); step();
        check("rr_exit_first", 32'(exit_gate_open), 32'd1);
        check("rr_no_entry", 32'(entry_gate_open), 32'd0);
        set_in(1, 0, 0, 1); step();
        check("rr_back_idle", 32'(busy), 32'd0);
        set_in(1, 0, 0, 0); step();
        check("rr_entry_next", 32'(entry_gate_open), 32'd1);
        check("rr_entry_slot", 32'(assigned_slot), 32'd0);
        set_in(0, 0, 0, 1); step();

        // Exit request for an empty slot
        do_reset();
        set_in(1, 0, 0, 0); step();
        set_in(0, 0, 0, 1); step();
        set_in(0, 1, 5, 0); step();
        check("err_pulse", 32'(exit_err), 32'd1);
        check("err_no_gate", 32'(exit_gate_open), 32'd0);
        check("err_occ", 32'(occupancy), 32'h01);
        set_in(0, 0, 0, 0); step();
        check("err_one_cycle", 32'(exit_err), 32'd0);

        // Asynchronous reset while the entry gate is up
        set_in(1, 0, 0, 0); step();
        check("pre_rst_gate", 32'(entry_gate_open), 32'd1);
        set_in(0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("rst_gate_drop", 32'(entry_gate_open), 32'd0);
        check("rst_occ_clear", 32'(occupancy), 32'h00);
        do_reset();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            set_in(($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                   int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
            step();
        end

`ifdef GATE_TIMEOUT_EN
        // Entry gate left open with no car: slot reservation is released
        do_reset();
        set_in(1, 0, 0, 0); step();
        set_in(0, 0, 0, 0);
        begin
            int waited = 0;
            while (!timeout_pulse && waited < 400) begin
                step();
                waited++;
            end
            check("tmo_seen", 32'(timeout_pulse), 32'd1);
            check("tmo_occ", 32'(occupancy), 32'h00);
            check("tmo_gate", 32'(entry_gate_open), 32'd0);
        end
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
